// File: rtl/dcm_ctrl.sv
// dcm_ctrl: sequences the DCM reset, qualifies lock, and gates the downstream system reset.
// Define DCM_CTRL_LOSS_CNT_EN to add the lock_loss_cnt output.
module dcm_ctrl #(
  parameter int unsigned RST_CYCLES   = 8,
  parameter int unsigned LOCK_TIMEOUT = 40000,
  parameter int unsigned LOCK_STABLE  = 256,
  parameter int unsigned MAX_RETRY    = 15
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       locked_in,
  input  logic [7:0] status_in,
  input  logic       relock_req,
  output logic       dcm_reset,
  output logic       sys_reset,
  output logic       clk_ok,
  output logic       fail,
`ifdef DCM_CTRL_LOSS_CNT_EN
  output logic [7:0] lock_loss_cnt,
`endif
  output logic [3:0] retry_cnt
);

  localparam int unsigned MaxA   = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned MaxCnt = (MaxA > LOCK_STABLE) ? MaxA : LOCK_STABLE;
  localparam int unsigned CntW   = $clog2(MaxCnt);

  localparam logic [CntW-1:0] LdRst     = CntW'(RST_CYCLES - 1);
  localparam logic [CntW-1:0] LdTimeout = CntW'(LOCK_TIMEOUT - 1);
  localparam logic [CntW-1:0] LdStable  = CntW'(LOCK_STABLE - 1);
  localparam logic [CntW-1:0] CntOne    = CntW'(1);
  localparam logic [3:0]      MaxRetry  = 4'(MAX_RETRY);

  localparam logic [2:0] StRstAssert = 3'd0;
  localparam logic [2:0] StWaitLock  = 3'd1;
  localparam logic [2:0] StStableChk = 3'd2;
  localparam logic [2:0] StRun       = 3'd3;
  localparam logic [2:0] StFail      = 3'd4;

  logic [2:0]      r_state, w_state_d;
  logic [CntW-1:0] r_cnt, w_cnt_d;
  logic [3:0]      r_retry_cnt, w_retry_cnt_d;
  logic            r_lock_meta, r_lock_s, r_fx_meta, r_fx_s;
  logic            r_dcm_reset, r_sys_reset, r_clk_ok, r_fail;
  logic            w_good, w_loss_event;
  logic            w_unused_status;

  assign w_unused_status = ^{status_in[7:3], status_in[1:0]};
  assign w_good          = r_lock_s & ~r_fx_s;

  always_comb begin
    w_state_d     = r_state;
    w_cnt_d       = r_cnt;
    w_retry_cnt_d = r_retry_cnt;
    w_loss_event  = 1'b0;
    case (r_state)
      StRstAssert: begin
        if (relock_req) begin
          w_cnt_d = LdRst;
        end else if (r_cnt == '0) begin
          w_cnt_d   = LdTimeout;
          w_state_d = StWaitLock;
        end else begin
          w_cnt_d = r_cnt - CntOne;
        end
      end
      StWaitLock: begin
        if (relock_req) begin
          w_cnt_d   = LdRst;
          w_state_d = StRstAssert;
        end else if (w_good) begin
          w_cnt_d   = LdStable;
          w_state_d = StStableChk;
        end else if (r_cnt == '0) begin
          if (r_retry_cnt == MaxRetry) begin
            w_state_d = StFail;
          end else begin
            w_retry_cnt_d = r_retry_cnt + 4'd1;
            w_cnt_d       = LdRst;
            w_state_d     = StRstAssert;
          end
        end else begin
          w_cnt_d = r_cnt - CntOne;
        end
      end
      StStableChk: begin
        if (relock_req) begin
          w_cnt_d   = LdRst;
          w_state_d = StRstAssert;
        end else if (!w_good) begin
          if (r_retry_cnt == MaxRetry) begin
            w_state_d = StFail;
          end else begin
            w_retry_cnt_d = r_retry_cnt + 4'd1;
            w_cnt_d       = LdRst;
            w_state_d     = StRstAssert;
          end
        end else if (r_cnt == '0) begin
          w_state_d = StRun;
        end else begin
          w_cnt_d = r_cnt - CntOne;
        end
      end
      StRun: begin
        // A lost lock and an explicit relock both start a fresh sequence; only loss is counted.
        if (relock_req || !w_good) begin
          w_loss_event  = !relock_req;
          w_retry_cnt_d = 4'd0;
          w_cnt_d       = LdRst;
          w_state_d     = StRstAssert;
        end
      end
      StFail: begin
        if (relock_req) begin
          w_retry_cnt_d = 4'd0;
          w_cnt_d       = LdRst;
          w_state_d     = StRstAssert;
        end
      end
      default: begin
        w_retry_cnt_d = 4'd0;
        w_cnt_d       = LdRst;
        w_state_d     = StRstAssert;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_state     <= StRstAssert;
      r_cnt       <= LdRst;
      r_retry_cnt <= 4'd0;
      r_lock_meta <= 1'b0;
      r_lock_s    <= 1'b0;
      r_fx_meta   <= 1'b0;
      r_fx_s      <= 1'b0;
      r_dcm_reset <= 1'b1;
      r_sys_reset <= 1'b1;
      r_clk_ok    <= 1'b0;
      r_fail      <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_cnt       <= w_cnt_d;
      r_retry_cnt <= w_retry_cnt_d;
      r_lock_meta <= locked_in;
      r_lock_s    <= r_lock_meta;
      r_fx_meta   <= status_in[2];
      r_fx_s      <= r_fx_meta;
      // Outputs decode the next state so they change on the same edge as the state.
      r_dcm_reset <= (w_state_d == StRstAssert) || (w_state_d == StFail);
      r_sys_reset <= (w_state_d != StRun);
      r_clk_ok    <= (w_state_d == StRun);
      r_fail      <= (w_state_d == StFail);
    end
  end

  assign dcm_reset = r_dcm_reset;
  assign sys_reset = r_sys_reset;
  assign clk_ok    = r_clk_ok;
  assign fail      = r_fail;
  assign retry_cnt = r_retry_cnt;

`ifdef DCM_CTRL_LOSS_CNT_EN
  logic [7:0] r_loss_cnt;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_loss_cnt <= 8'd0;
    end else if (w_loss_event && (r_loss_cnt != 8'hff)) begin
      r_loss_cnt <= r_loss_cnt + 8'd1;
    end
  end

  assign lock_loss_cnt = r_loss_cnt;
`else
  logic w_unused_loss;
  assign w_unused_loss = w_loss_event;
`endif

endmodule

// File: tb/tb_dcm_ctrl.sv
// Directed bench for dcm_ctrl with short parameters (4/20/8/2).
module tb_dcm_ctrl;

  logic       clk_in = 1'b0;
  logic       reset;
  logic       locked_in;
  logic [7:0] status_in;
  logic       relock_req;
  logic       dcm_reset, sys_reset, clk_ok, fail;
  logic [3:0] retry_cnt;
`ifdef DCM_CTRL_LOSS_CNT_EN
  logic [7:0] lock_loss_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int n;
  logic sys_seen_low;

  always #5 clk_in = ~clk_in;

  dcm_ctrl #(
    .RST_CYCLES  (4),
    .LOCK_TIMEOUT(20),
    .LOCK_STABLE (8),
    .MAX_RETRY   (2)
  ) u_dut (
    .clk_in       (clk_in),
    .reset        (reset),
    .locked_in    (locked_in),
    .status_in    (status_in),
    .relock_req   (relock_req),
    .dcm_reset    (dcm_reset),
    .sys_reset    (sys_reset),
    .clk_ok       (clk_ok),
    .fail         (fail),
`ifdef DCM_CTRL_LOSS_CNT_EN
    .lock_loss_cnt(lock_loss_cnt),
`endif
    .retry_cnt    (retry_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Ticks until the selected output (0: dcm_reset, 1: sys_reset) equals lvl; bounded.
  task automatic count_until(input int which, input logic lvl, output int cnt);
    logic sig;
    cnt = 0;
    do begin
      tick();
      cnt++;
      sig = (which == 0) ? dcm_reset : sys_reset;
    end while (sig !== lvl && cnt < 200);
  endtask

  task automatic pulse_relock();
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    locked_in  = 1'b0;
    status_in  = 8'h00;
    relock_req = 1'b0;
    tick();
    tick();
    check("rst_dcm_reset", dcm_reset, 1);
    check("rst_sys_reset", sys_reset, 1);
    check("rst_clk_ok", clk_ok, 0);
    check("rst_fail", fail, 0);
    check("rst_retry", retry_cnt, 0);
`ifdef DCM_CTRL_LOSS_CNT_EN
    check("rst_loss_cnt", lock_loss_cnt, 0);
`endif
    reset = 1'b0;

    // Normal lock
    count_until(0, 1'b0, n);
    check("norm_pulse_len", n, 4);
    repeat (3) tick();
    locked_in = 1'b1;
    count_until(1, 1'b0, n);
    check("norm_release_lat", n, 11);
    check("norm_clk_ok", clk_ok, 1);
    check("norm_dcm_reset", dcm_reset, 0);
    check("norm_retry", retry_cnt, 0);
    check("norm_fail", fail, 0);

    // Loss of lock in RUN
    locked_in = 1'b0;
    count_until(1, 1'b1, n);
    check("loss_lat", n, 3);
    check("loss_clk_ok", clk_ok, 0);
    check("loss_dcm_reset", dcm_reset, 1);
    check("loss_retry", retry_cnt, 0);
`ifdef DCM_CTRL_LOSS_CNT_EN
    check("loss_cnt_1", lock_loss_cnt, 1);
`endif
    count_until(0, 1'b0, n);
    check("loss_pulse_len", n, 4);

    // Unstable lock during the stable window
    locked_in    = 1'b1;
    sys_seen_low = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (sys_reset !== 1'b1) sys_seen_low = 1'b1;
    end
    locked_in = 1'b0;
    count_until(0, 1'b1, n);
    check("unstable_retry_lat", n, 3);
    check("unstable_sys_held", sys_seen_low, 0);
    check("unstable_retry", retry_cnt, 1);
    count_until(0, 1'b0, n);
    check("unstable_pulse_len", n, 4);

    // Relock in WAIT_LOCK keeps the retry count
    repeat (3) tick();
    pulse_relock();
    check("wait_relock_dcm", dcm_reset, 1);
    check("wait_relock_retry", retry_cnt, 1);
    count_until(0, 1'b0, n);
    check("wait_relock_pulse", n, 4);

    // Reset in WAIT_LOCK
    repeat (5) tick();
    reset = 1'b1;
    tick();
    check("midrst_dcm", dcm_reset, 1);
    check("midrst_retry", retry_cnt, 0);
    check("midrst_sys", sys_reset, 1);
    reset = 1'b0;
    count_until(0, 1'b0, n);
    check("midrst_pulse", n, 4);

    // Timeout, retries and FAIL
    for (int a = 0; a < 3; a++) begin
      count_until(0, 1'b1, n);
      check("timeout_wait", n, 20);
      if (a < 2) begin
        check("timeout_retry", retry_cnt, a + 1);
        check("timeout_fail_low", fail, 0);
        count_until(0, 1'b0, n);
        check("timeout_pulse", n, 4);
      end
    end
    check("fail_flag", fail, 1);
    check("fail_retry", retry_cnt, 2);
    check("fail_sys", sys_reset, 1);
    repeat (10) tick();
    check("fail_hold_flag", fail, 1);
    check("fail_hold_dcm", dcm_reset, 1);
    check("fail_hold_clk_ok", clk_ok, 0);

    // Relock out of FAIL
    pulse_relock();
    check("failrelock_fail", fail, 0);
    check("failrelock_retry", retry_cnt, 0);
    check("failrelock_dcm", dcm_reset, 1);
    count_until(0, 1'b0, n);
    check("failrelock_pulse", n, 4);
    locked_in = 1'b1;
    count_until(1, 1'b0, n);
    check("failrelock_lat", n, 11);
    check("failrelock_clk_ok", clk_ok, 1);

    // Relock request in RUN is not a loss
    pulse_relock();
    check("runrelock_sys", sys_reset, 1);
    check("runrelock_clk_ok", clk_ok, 0);
    check("runrelock_retry", retry_cnt, 0);
`ifdef DCM_CTRL_LOSS_CNT_EN
    check("runrelock_loss_cnt", lock_loss_cnt, 1);
`endif
    count_until(0, 1'b0, n);
    check("runrelock_pulse", n, 4);
    count_until(1, 1'b0, n);
    check("runrelock_lat", n, 9);

    // CLKFX stopped in RUN
    status_in = 8'h04;
    count_until(1, 1'b1, n);
    check("fxstop_lat", n, 3);
    check("fxstop_clk_ok", clk_ok, 0);
    check("fxstop_dcm", dcm_reset, 1);
`ifdef DCM_CTRL_LOSS_CNT_EN
    check("fxstop_loss_cnt", lock_loss_cnt, 2);
`endif
    status_in = 8'h00;
    count_until(0, 1'b0, n);
    check("fxstop_pulse", n, 4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dcm_ctrl.md
Name: dcm_ctrl

Overview:
Supervisor for the DCM clock wrapper. It drives the DCM reset, watches the DCM locked and status outputs, and releases a downstream system reset only after a stable lock. It re-resets the DCM on timeout or loss of lock, and latches a fail flag after repeated failed attempts. It runs on the free-running board input clock that also feeds the DCM.

Parameters:
RST_CYCLES, 8, number of cycles dcm_reset is held high per attempt (DCM_SP needs ≥3); legal range ≥3.
LOCK_TIMEOUT, 40000, cycles allowed for lock after dcm_reset release (1 ms at 25 ns).
LOCK_STABLE, 256, consecutive cycles locked must hold, with CLKFX not stopped, before release.
MAX_RETRY, 15, retries allowed before entering FAIL; range 0..15.

Ports:
clk_in  input  1  free-running input clock (same net as the DCM input clock)
reset  input  1  synchronous, active-high reset
locked_in  input  1  DCM locked output; treated as asynchronous
status_in  input  8  DCM STATUS bus; only bit 2 (CLKFX stopped) is used; treated as asynchronous
relock_req  input  1  one-cycle request to force a new lock sequence
dcm_reset  output  1  reset to the DCM
sys_reset  output  1  reset for logic clocked by the DCM output
clk_ok  output  1  high while in RUN
fail  output  1  high while in FAIL
retry_cnt  output  4  number of failed attempts in the current sequence

Behaviour:
- Synchronisers:
  - locked_in and status_in[2] each pass through a 2-flop synchroniser, giving lock_s and fxstop_s (2-cycle latency).
  - "good" = lock_s & ~fxstop_s.
- Counters and outputs:
  - One shared down-counter, sized by $clog2 of the largest parameter.
  - All outputs are registered and decoded from state.
- Reset (synchronous, highest priority):
  - state = RST_ASSERT, counter = RST_CYCLES-1, retry_cnt = 0.
  - dcm_reset = 1, sys_reset = 1, clk_ok = 0, fail = 0.
  - Synchroniser flops clear to 0.
- RST_ASSERT:
  - dcm_reset = 1, sys_reset = 1.
  - Counter decrements each cycle.
  - At 0: load LOCK_TIMEOUT-1 and go to WAIT_LOCK.
  - dcm_reset is therefore high for exactly RST_CYCLES cycles per attempt.
- WAIT_LOCK:
  - dcm_reset = 0, sys_reset = 1.
  - If good: load LOCK_STABLE-1 and go to STABLE_CHK.
  - Else, if counter = 0: take the retry path.
  - Else: decrement.
  - If good coincides with counter = 0, good wins.
- STABLE_CHK:
  - dcm_reset = 0, sys_reset = 1.
  - If not good: take the retry path.
  - Else, if counter = 0: go to RUN.
  - Else: decrement.
- Retry path:
  - If retry_cnt = MAX_RETRY: go to FAIL.
  - Else: retry_cnt += 1, load RST_CYCLES-1, go to RST_ASSERT.
- RUN:
  - dcm_reset = 0, sys_reset = 0, clk_ok = 1.
  - On not good: retry_cnt = 0, go to RST_ASSERT; sys_reset reasserts on the next cycle.
  - On relock_req: same action as not good.
- FAIL:
  - dcm_reset = 1, sys_reset = 1, fail = 1; retry_cnt holds its value.
  - Exit only by reset, or by relock_req (retry_cnt = 0, go to RST_ASSERT).
- relock_req in RST_ASSERT, WAIT_LOCK or STABLE_CHK: restart RST_ASSERT with a full count; retry_cnt is unchanged.
- Transition priority: reset > relock_req > not good > counter expiry.
- retry_cnt never wraps; it is bounded by MAX_RETRY.
- Once locked_in is high, sys_reset deasserts exactly 2 + LOCK_STABLE + 1 cycles later (synchroniser latency, stable window, output register).

Optional Feature:
DCM_CTRL_LOSS_CNT_EN
- Defined:
  - Adds output port lock_loss_cnt, 8 bits.
  - Increments on each RUN→RST_ASSERT transition caused by not good; relock_req does not count.
  - Saturates at 255 and clears only on reset.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
All scenarios use RST_CYCLES=4, LOCK_TIMEOUT=20, LOCK_STABLE=8, MAX_RETRY=2.
- Normal lock: reset, then hold locked_in=1 from 3 cycles after dcm_reset falls -> dcm_reset high exactly 4 cycles; sys_reset falls 11 cycles after locked_in rises; clk_ok=1; retry_cnt=0.
- Timeout and fail: locked_in held 0 -> 3 RST_ASSERT pulses of 4 cycles, separated by 20-cycle waits; retry_cnt goes 1, 2; then fail=1 with dcm_reset=1 and sys_reset=1, both held.
- Unstable lock: locked_in high 5 cycles then low during STABLE_CHK -> retry_cnt=1, new 4-cycle dcm_reset pulse, sys_reset never deasserts.
- Loss in RUN: in RUN, drop locked_in (or raise status_in[2]) -> sys_reset=1 and clk_ok=0 3 cycles later (2-flop synchroniser plus output register); DCM re-reset; retry_cnt=0; with DCM_CTRL_LOSS_CNT_EN, lock_loss_cnt increments 0→1.
- Relock request: pulse relock_req in FAIL -> fail=0, retry_cnt=0, new sequence; pulse in RUN -> re-lock sequence; lock_loss_cnt unchanged.
- Reset mid-operation: assert reset during WAIT_LOCK -> next cycle dcm_reset=1, retry_cnt=0, full 4-cycle pulse after reset drops.
